// File: rtl/rx_ltssm_sequencer.sv
// rx_ltssm_sequencer
// Sequences the receive-side link-training substates on behalf of a master
// RX LTSSM. It issues substate requests, waits for the master to report
// completion, follows the reported next substate, retries failed substates
// up to a limit, and guards each wait with a watchdog. A small independent
// tick timer is included for the master's substate timeouts.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous active-high reset
//   start        in   request training (sampled only in IDLE)
//   forceDetect  in   abort training and restart at detectQuiet
//   finish       in   one-cycle completion pulse from the master
//   exitTo[3:0]  in   master-reported next substate, qualified by finish
//   setTimer[5:0] in  timer timeout value in ticks
//   enableTimer  in   timer run
//   resetTimer   in   active-low timer clear
//   tick         in   one-cycle timebase pulse
//   substate[3:0] out substate request (0 detectQuiet .. 9 configurationIdle)
//   timeOut      out  timer expired (combinational from registered count)
//   busy         out  training in progress (ISSUE/WAIT)
//   linkUp       out  training completed
//   error        out  retry limit reached
//   retryCount[3:0] out failures since start (saturating)
//   dbgState[2:0] out current FSM state encoding
//
// Handshake: finish is a single-cycle qualifier; exitTo is only looked at
// in a cycle where finish=1 and the FSM is in WAIT. There is no back-pressure.
module rx_ltssm_sequencer #(
   parameter int MAXRETRY = 4,
   parameter int WDOG     = 1023
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       forceDetect,
   input  logic       finish,
   input  logic [3:0] exitTo,
   input  logic [5:0] setTimer,
   input  logic       enableTimer,
   input  logic       resetTimer,
   input  logic       tick,
   output logic [3:0] substate,
   output logic       timeOut,
   output logic       busy,
   output logic       linkUp,
   output logic       error,
   output logic [3:0] retryCount,
   output logic [2:0] dbgState
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ISSUE  = 3'd1,
      WAIT   = 3'd2,
      LINKUP = 3'd3,
      ERROR  = 3'd4
   } stateT;

   localparam int WDW = (WDOG < 2) ? 1 : $clog2(WDOG + 1);

   stateT          state;
   logic [WDW-1:0] wdogCnt;
   logic [5:0]     timerCnt;

   logic [3:0] retryNext;
   logic       retryHit;
   logic       goodExit;
   logic       wdogExpire;
   logic       failEvent;

   assign dbgState = state;

   // Retry counter saturates so a large MAXRETRY can never wrap it.
   assign retryNext  = (retryCount == 4'd15) ? 4'd15 : retryCount + 4'd1;
   assign retryHit   = (int'(retryNext) == MAXRETRY);

   // 1..10 are real destinations; 0 and 11..15 are all treated as failure.
   assign goodExit   = (exitTo >= 4'd1) && (exitTo <= 4'd10);
   // Fires on the WDOG-th consecutive WAIT cycle without finish.
   assign wdogExpire = (wdogCnt == WDW'(WDOG - 1));
   assign failEvent  = finish ? !goodExit : wdogExpire;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         substate   <= 4'd0;
         retryCount <= 4'd0;
         busy       <= 1'b0;
         linkUp     <= 1'b0;
         error      <= 1'b0;
         wdogCnt    <= '0;
      end else if (forceDetect || (state == IDLE && start)) begin
         // forceDetect outranks any same-cycle finish or watchdog expiry,
         // and in IDLE it behaves exactly like start.
         state      <= ISSUE;
         substate   <= 4'd0;
         retryCount <= 4'd0;
         busy       <= 1'b1;
         linkUp     <= 1'b0;
         error      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               substate <= 4'd0;
            end
            ISSUE: begin
               state   <= WAIT;
               wdogCnt <= '0;
            end
            WAIT: begin
               if (finish && exitTo == 4'd10) begin
                  state    <= LINKUP;
                  substate <= 4'd9;
                  busy     <= 1'b0;
                  linkUp   <= 1'b1;
               end else if (finish && goodExit) begin
                  state    <= ISSUE;
                  substate <= exitTo;
               end else if (failEvent) begin
                  if (substate == 4'd0) begin
                     // Failing detectQuiet itself just re-issues it.
                     state <= ISSUE;
                  end else begin
                     retryCount <= retryNext;
                     if (retryHit) begin
                        state <= ERROR;
                        busy  <= 1'b0;
                        error <= 1'b1;
                     end else begin
                        state    <= ISSUE;
                        substate <= 4'd0;
                     end
                  end
               end else begin
                  wdogCnt <= wdogCnt + WDW'(1);
               end
            end
            LINKUP, ERROR: begin
               // Terminal until forceDetect or reset.
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Tick timer: cleared whenever disabled or held in clear, otherwise
   // counts ticks and stops at setTimer.
   always_ff @(posedge clk) begin
      if (reset || !enableTimer || !resetTimer) begin
         timerCnt <= 6'd0;
      end else if (tick && (timerCnt < setTimer)) begin
         timerCnt <= timerCnt + 6'd1;
      end
   end

   assign timeOut = enableTimer && resetTimer && (timerCnt == setTimer);

endmodule

// File: tb/tb_rx_ltssm_sequencer.sv
// Testbench for rx_ltssm_sequencer (MAXRETRY=4, WDOG=8).
// Each driven cycle pushes the expected output snapshot; a monitor pops and
// compares it one time unit after the clock edge that produced it.
module tb_rx_ltssm_sequencer;

   localparam int W = 15;
   localparam logic [2:0] sIdle   = 3'd0;
   localparam logic [2:0] sIssue  = 3'd1;
   localparam logic [2:0] sWait   = 3'd2;
   localparam logic [2:0] sLinkUp = 3'd3;
   localparam logic [2:0] sError  = 3'd4;

   logic       clk;
   logic       reset;
   logic       start;
   logic       forceDetect;
   logic       finish;
   logic [3:0] exitTo;
   logic [5:0] setTimer;
   logic       enableTimer;
   logic       resetTimer;
   logic       tick;
   logic [3:0] substate;
   logic       timeOut;
   logic       busy;
   logic       linkUp;
   logic       error;
   logic [3:0] retryCount;
   logic [2:0] dbgState;

   logic [W-1:0] obsVec;
   logic [W-1:0] exp_q[$];
   string        tag_q[$];
   int           checks;
   int           errors;

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   rx_ltssm_sequencer #(.MAXRETRY(4), .WDOG(8)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .forceDetect(forceDetect),
      .finish(finish),
      .exitTo(exitTo),
      .setTimer(setTimer),
      .enableTimer(enableTimer),
      .resetTimer(resetTimer),
      .tick(tick),
      .substate(substate),
      .timeOut(timeOut),
      .busy(busy),
      .linkUp(linkUp),
      .error(error),
      .retryCount(retryCount),
      .dbgState(dbgState)
   );

   assign obsVec = {dbgState, substate, retryCount, busy, linkUp, error, timeOut};

   function automatic logic [W-1:0] mk(input logic [2:0] st, input logic [3:0] sub,
                                       input logic [3:0] rc, input logic b,
                                       input logic lu, input logic er, input logic to);
      return {st, sub, rc, b, lu, er, to};
   endfunction

   task automatic checkVal(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got st=%0d sub=%0d rc=%0d busy=%b lu=%b err=%b to=%b, expected st=%0d sub=%0d rc=%0d busy=%b lu=%b err=%b to=%b",
                  tag, obs[14:12], obs[11:8], obs[7:4], obs[3], obs[2], obs[1], obs[0],
                  exp[14:12], exp[11:8], exp[7:4], exp[3], exp[2], exp[1], exp[0]);
      end
   endtask

   // scoreboard monitor
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         checkVal(tag_q.pop_front(), obsVec, exp_q.pop_front());
      end
   end

   // driver: one clock of stimulus, pulse inputs dropped afterwards
   task automatic cyc(input logic st, input logic fd, input logic fin, input logic [3:0] ex,
                      input logic tk, input string tag, input logic [W-1:0] e);
      start       = st;
      forceDetect = fd;
      finish      = fin;
      exitTo      = ex;
      tick        = tk;
      @(posedge clk);
      exp_q.push_back(e);
      tag_q.push_back(tag);
      #2;
      start       = 1'b0;
      forceDetect = 1'b0;
      finish      = 1'b0;
      exitTo      = 4'd0;
      tick        = 1'b0;
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      reset       = 1'b1;
      start       = 1'b0;
      forceDetect = 1'b0;
      finish      = 1'b0;
      exitTo      = 4'd0;
      setTimer    = 6'd0;
      enableTimer = 1'b0;
      resetTimer  = 1'b1;
      tick        = 1'b0;

      // reset
      cyc(0, 0, 0, 0, 0, "reset",      mk(sIdle, 0, 0, 0, 0, 0, 0));
      cyc(1, 0, 1, 4'd3, 0, "resetStart", mk(sIdle, 0, 0, 0, 0, 0, 0));
      reset = 1'b0;
      cyc(0, 0, 0, 0, 0, "idleHold",   mk(sIdle, 0, 0, 0, 0, 0, 0));

      // timer
      enableTimer = 1'b1; resetTimer = 1'b1; setTimer = 6'd3;
      cyc(0, 0, 0, 0, 1, "tmr1",       mk(sIdle, 0, 0, 0, 0, 0, 0));
      cyc(0, 0, 0, 0, 0, "tmrHold",    mk(sIdle, 0, 0, 0, 0, 0, 0));
      cyc(0, 0, 0, 0, 1, "tmr2",       mk(sIdle, 0, 0, 0, 0, 0, 0));
      cyc(0, 0, 0, 0, 1, "tmr3",       mk(sIdle, 0, 0, 0, 0, 0, 1));
      cyc(0, 0, 0, 0, 1, "tmrSat",     mk(sIdle, 0, 0, 0, 0, 0, 1));
      enableTimer = 1'b0;
      cyc(0, 0, 0, 0, 0, "tmrDis",     mk(sIdle, 0, 0, 0, 0, 0, 0));
      enableTimer = 1'b1;
      cyc(0, 0, 0, 0, 0, "tmrCleared", mk(sIdle, 0, 0, 0, 0, 0, 0));
      setTimer = 6'd0;
      cyc(0, 0, 0, 0, 0, "tmrZero",    mk(sIdle, 0, 0, 0, 0, 0, 1));
      resetTimer = 1'b0;
      cyc(0, 0, 0, 0, 0, "tmrRstLow",  mk(sIdle, 0, 0, 0, 0, 0, 0));
      resetTimer = 1'b1; enableTimer = 1'b0; setTimer = 6'd3;

      // happy path
      cyc(1, 0, 0, 0, 0, "hpStart",    mk(sIssue, 0, 0, 1, 0, 0, 0));
      cyc(0, 0, 0, 0, 0, "hpWait0",    mk(sWait, 0, 0, 1, 0, 0, 0));
      for (int k = 1; k <= 9; k++) begin
         cyc(0, 0, 1, 4'(k), 0, "hpIssue", mk(sIssue, 4'(k), 0, 1, 0, 0, 0));
         cyc(0, 0, 0, 0, 0, "hpWait",      mk(sWait, 4'(k), 0, 1, 0, 0, 0));
      end
      cyc(0, 0, 1, 4'd10, 0, "hpLinkUp", mk(sLinkUp, 9, 0, 0, 1, 0, 0));
      cyc(1, 0, 0, 0, 0, "luIgnStart",  mk(sLinkUp, 9, 0, 0, 1, 0, 0));
      cyc(0, 0, 1, 4'd2, 0, "luIgnFin", mk(sLinkUp, 9, 0, 0, 1, 0, 0));
      cyc(0, 1, 0, 0, 0, "luForce",     mk(sIssue, 0, 0, 1, 0, 0, 0));
      cyc(0, 0, 0, 0, 0, "rtWait",      mk(sWait, 0, 0, 1, 0, 0, 0));

      // retry limit
      cyc(0, 0, 1, 4'd2, 0, "rtTo2a",     mk(sIssue, 2, 0, 1, 0, 0, 0));
      cyc(0, 0, 0, 0, 0,    "rtW2a",      mk(sWait, 2, 0, 1, 0, 0, 0));
      cyc(0, 0, 1, 4'd0, 0, "retry1",     mk(sIssue, 0, 1, 1, 0, 0, 0));
      cyc(0, 0, 0, 0, 0,    "rtW0a",      mk(sWait, 0, 1, 1, 0, 0, 0));
      cyc(0, 0, 1, 4'd0, 0, "sub0NoRetry", mk(sIssue, 0, 1, 1, 0, 0, 0));
      cyc(0, 0, 0, 0, 0,    "rtW0b",      mk(sWait, 0, 1, 1, 0, 0, 0));
      cyc(0, 0, 1, 4'd2, 0, "rtTo2b",     mk(sIssue, 2, 1, 1, 0, 0, 0));
      cyc(0, 0, 0, 0, 0,    "rtW2b",      mk(sWait, 2, 1, 1, 0, 0, 0));
      cyc(0, 0, 1, 4'd12, 0, "retry2Ex12", mk(sIssue, 0, 2, 1, 0, 0, 0));
      cyc(0, 0, 0, 0, 0,    "rtW0c",      mk(sWait, 0, 2, 1, 0, 0, 0));
      cyc(0, 0, 1, 4'd2, 0, "rtTo2c",     mk(sIssue, 2, 2, 1, 0, 0, 0));
      cyc(0, 0, 0, 0, 0,    "rtW2c",      mk(sWait, 2, 2, 1, 0, 0, 0));
      cyc(0, 0, 1, 4'd0, 0, "retry3",     mk(sIssue, 0, 3, 1, 0, 0, 0));
      cyc(0, 0, 0, 0, 0,    "rtW0d",      mk(sWait, 0, 3, 1, 0, 0, 0));
      cyc(0, 0, 1, 4'd2, 0, "rtTo2d",     mk(sIssue, 2, 3, 1, 0, 0, 0));
      cyc(0, 0, 0, 0, 0,    "rtW2d",      mk(sWait, 2, 3, 1, 0, 0, 0));
      cyc(0, 0, 1, 4'd0, 0, "retry4Err",  mk(sError, 2, 4, 0, 0, 1, 0));
      cyc(1, 0, 0, 0, 0,    "errIgnStart", mk(sError, 2, 4, 0, 0, 1, 0));
      cyc(0, 0, 1, 4'd3, 0, "errIgnFin",  mk(sError, 2, 4, 0, 0, 1, 0));
      cyc(0, 1, 0, 0, 0,    "errForce",   mk(sIssue, 0, 0, 1, 0, 0, 0));

      // watchdog from substate 0: no retry increment
      for (int i = 0; i < 8; i++) begin
         cyc(0, 0, 0, 0, 0, "wdogWait0", mk(sWait, 0, 0, 1, 0, 0, 0));
      end
      cyc(0, 0, 0, 0, 0, "wdogSub0",     mk(sIssue, 0, 0, 1, 0, 0, 0));
      cyc(0, 0, 0, 0, 0, "wdogW0",       mk(sWait, 0, 0, 1, 0, 0, 0));
      cyc(0, 0, 1, 4'd3, 0, "wdogTo3",   mk(sIssue, 3, 0, 1, 0, 0, 0));
      // watchdog from substate 3: counts as a failure
      for (int i = 0; i < 8; i++) begin
         cyc(0, 0, 0, 0, 0, "wdogWait3", mk(sWait, 3, 0, 1, 0, 0, 0));
      end
      cyc(0, 0, 0, 0, 0, "wdogSub3",     mk(sIssue, 0, 1, 1, 0, 0, 0));

      // forceDetect beats a same-cycle finish
      cyc(0, 0, 0, 0, 0,    "prioWait",  mk(sWait, 0, 1, 1, 0, 0, 0));
      cyc(0, 1, 1, 4'd5, 0, "prio",      mk(sIssue, 0, 0, 1, 0, 0, 0));

      // reset mid-WAIT at substate 7
      cyc(0, 0, 0, 0, 0,    "rsW0",      mk(sWait, 0, 0, 1, 0, 0, 0));
      cyc(0, 0, 1, 4'd7, 0, "rsTo7",     mk(sIssue, 7, 0, 1, 0, 0, 0));
      cyc(0, 0, 0, 0, 0,    "rsW7",      mk(sWait, 7, 0, 1, 0, 0, 0));
      reset = 1'b1;
      cyc(0, 0, 1, 4'd10, 0, "rstMidWait", mk(sIdle, 0, 0, 0, 0, 0, 0));
      reset = 1'b0;
      cyc(0, 0, 0, 0, 0,    "idleAfterRst", mk(sIdle, 0, 0, 0, 0, 0, 0));
      cyc(0, 0, 1, 4'd3, 0, "idleIgnFin",   mk(sIdle, 0, 0, 0, 0, 0, 0));
      cyc(1, 0, 0, 0, 0,    "restart",      mk(sIssue, 0, 0, 1, 0, 0, 0));
      cyc(0, 0, 0, 0, 0,    "restartWait",  mk(sWait, 0, 0, 1, 0, 0, 0));

      // forceDetect in IDLE acts as start
      reset = 1'b1;
      cyc(0, 0, 0, 0, 0, "rst2",    mk(sIdle, 0, 0, 0, 0, 0, 0));
      reset = 1'b0;
      cyc(0, 1, 0, 0, 0, "fdIdle",  mk(sIssue, 0, 0, 1, 0, 0, 0));

      // final report
      @(posedge clk);
      #3;
      checkVal("drain", W'(exp_q.size()), W'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rx_ltssm_sequencer.md
RX_LTSSM_SEQUENCER -- requirements
Module: rx_ltssm_sequencer

Interface
REQ-001 The block SHALL have one clock, clk; reset is synchronous and active-high, port reset.
REQ-002 The block SHALL have parameter MAXRETRY, default 4: failed-substate retries allowed before error.
REQ-003 The block SHALL have parameter WDOG, default 1023: clk cycles allowed in WAIT before forced failure.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port reset, input, 1: synchronous active-high reset.
REQ-006 Port start, input, 1: request link training; sampled only in IDLE.
REQ-007 Port forceDetect, input, 1: abort any training and restart at detectQuiet.
REQ-008 Port finish, input, 1: one-cycle completion pulse from the master RX LTSSM.
REQ-009 Port exitTo, input, 4: master-reported next substate, valid with finish.
REQ-010 Port setTimer, input, 6: timeout value in ticks.
REQ-011 Port enableTimer, input, 1: timer run.
REQ-012 Port resetTimer, input, 1: active-low timer clear.
REQ-013 Port tick, input, 1: one-cycle timebase pulse.
REQ-014 Port substate, output, 4: substate request to master (0 detectQuiet .. 9 configurationIdle).
REQ-015 Port timeOut, output, 1: timer expired.
REQ-016 Port busy, output, 1: training in progress.
REQ-017 Port linkUp, output, 1: training completed.
REQ-018 Port error, output, 1: retry limit reached.
REQ-019 Port retryCount, output, 4: failures since start.

Function
REQ-020 The FSM SHALL have states IDLE, ISSUE, WAIT, LINKUP, ERROR.
REQ-021 IDLE: substate=0; start=1 -> ISSUE with substate=0, retryCount=0, linkUp=0, error=0.
REQ-022 ISSUE SHALL last exactly one cycle, then WAIT; the watchdog counter SHALL clear on entry to WAIT.
REQ-023 WAIT with finish=1 and exitTo=10 SHALL go to LINKUP the next cycle: linkUp=1, busy=0, substate held at 9.
REQ-024 WAIT with finish=1 and exitTo in 1..9 SHALL load substate=exitTo and go to ISSUE.
REQ-025 WAIT with finish=1 and exitTo=0 while substate=0 SHALL re-ISSUE substate 0 without incrementing retryCount.
REQ-026 WAIT with finish=1 and exitTo=0 while substate!=0 SHALL increment retryCount: if the new value equals MAXRETRY -> ERROR, else substate=0 and ISSUE.
REQ-027 WAIT with no finish for WDOG consecutive cycles SHALL be treated as exitTo=0 (REQ-025/026).
REQ-028 exitTo values 11..15 with finish SHALL be treated as exitTo=0.
REQ-029 LINKUP and ERROR SHALL hold until forceDetect or reset; start SHALL be ignored in those states.
REQ-030 forceDetect=1 in any state other than IDLE SHALL go to ISSUE with substate=0, retryCount=0, linkUp=0, error=0; it SHALL take priority over a same-cycle finish or watchdog expiry.
REQ-031 forceDetect in IDLE SHALL act as start.
REQ-032 busy SHALL be 1 in ISSUE and WAIT only.
REQ-033 The timer SHALL be a 6-bit counter:
- cleared when enableTimer=0 or resetTimer=0;
- otherwise incremented on tick;
- saturating at setTimer.
REQ-034 timeOut SHALL equal enableTimer AND resetTimer AND (count==setTimer), evaluated combinationally from the registered count; setTimer=0 gives immediate timeOut.
REQ-035 retryCount SHALL saturate at 15.
REQ-036 All outputs except timeOut SHALL be registered.

Reset
REQ-037 reset=1 at a clk edge SHALL force IDLE and set substate=0, retryCount=0, busy=0, linkUp=0, error=0, timer=0, watchdog=0.
REQ-038 Reset SHALL override all other inputs, including mid-WAIT, and a finish arriving in the reset cycle SHALL be discarded.

Verification
REQ-039 Happy path: start, then finish with exitTo=1..9 and finally 10 -> substate steps 0..9, each value visible one cycle before WAIT; linkUp=1 one cycle after the final finish.
REQ-040 Retry limit (MAXRETRY=4): finish with exitTo=0 from substate 2, four times -> retryCount 1,2,3,4; error=1 and busy=0 after the fourth.
REQ-041 Watchdog (WDOG=8): start, then no finish -> forced failure in WAIT after 8 cycles; substate=0, retryCount unchanged.
REQ-042 Timer: setTimer=3, enableTimer=resetTimer=1, three tick pulses -> timeOut=1 after the third tick; deasserting enableTimer -> timeOut=0 the next cycle and count=0.
REQ-043 Priority: forceDetect and finish (exitTo=5) in the same cycle -> substate=0, retryCount=0, state ISSUE.
REQ-044 Reset mid-WAIT at substate 7 -> substate=0, busy=0 the next cycle; start is then required to resume.
